// File: rtl/bitstream_network.sv
// Stochastic-computing 2-2-1 network: bitstream inputs, LFSR-synthesised weight
// streams, MUX scaled adders and saturating-counter activations per neuron.
module bitstream_network #(
   parameter int         STATES = 16,
   parameter logic [8:0] W00    = 9'd128,
   parameter logic [8:0] W01    = 9'd128,
   parameter logic [8:0] W10    = 9'd128,
   parameter logic [8:0] W11    = 9'd128,
   parameter logic [8:0] V0     = 9'd128,
   parameter logic [8:0] V1     = 9'd128,
   parameter logic [7:0] SEED   = 8'h5A
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [1:0] network_input,
   output logic       network_output
);

   localparam int SW = (STATES > 1) ? $clog2(STATES) : 1;
   localparam logic [SW-1:0] RESET_STATE = SW'(STATES / 2 - 1);
   localparam logic [SW-1:0] MAX_STATE   = SW'(STATES - 1);
   localparam logic [SW-1:0] HALF_STATE  = SW'(STATES / 2);
   localparam int NUM_LFSR = 7;
   localparam logic [8:0] WEIGHTS [6] = '{W00, W01, W10, W11, V0, V1};

   function automatic logic [7:0] seed_of(input int n);
      logic [7:0] v;
      v = SEED ^ 8'(n);
      return (v == 8'h00) ? 8'h01 : v;
   endfunction

   function automatic logic [SW-1:0] step(input logic [SW-1:0] cur, input logic up);
      logic [SW-1:0] nxt;
      nxt = cur;
      if (up) begin
         if (cur != MAX_STATE) nxt = cur + SW'(1);
      end else begin
         if (cur != '0) nxt = cur - SW'(1);
      end
      return nxt;
   endfunction

   // Indices 0..5 feed W00,W01,W10,W11,V0,V1; index 6 is the shared select source.
   logic [NUM_LFSR-1:0][7:0] lfsr;
   logic [5:0]               w;
   logic                     sel;

   logic          in_j0, in_j1;
   logic          sum_h0, sum_h1, sum_out;
   logic          h0, h1;
   logic [SW-1:0] h0_state, h1_state, out_state;
   logic [SW-1:0] h0_next, h1_next, out_next;

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         for (int n = 0; n < NUM_LFSR; n++) lfsr[n] <= seed_of(n);
      end else begin
         for (int n = 0; n < NUM_LFSR; n++)
            lfsr[n] <= {lfsr[n][6:0], lfsr[n][7] ^ lfsr[n][5] ^ lfsr[n][4] ^ lfsr[n][3]};
      end
   end

   // Weight of 256 compares above every 8-bit value, giving a constant-one stream.
   always_comb begin
      w = '0;
      for (int i = 0; i < 6; i++) w[i] = ({1'b0, lfsr[i]} < WEIGHTS[i]);
   end

   assign sel   = lfsr[6][0];
   assign in_j0 = network_input[1];
   assign in_j1 = network_input[0];

   assign h0             = (h0_state >= HALF_STATE);
   assign h1             = (h1_state >= HALF_STATE);
   assign network_output = (out_state >= HALF_STATE);

   always_comb begin
      sum_h0   = sel ? (in_j1 & w[1]) : (in_j0 & w[0]);
      sum_h1   = sel ? (in_j1 & w[3]) : (in_j0 & w[2]);
      sum_out  = sel ? (h1 & w[5]) : (h0 & w[4]);
      h0_next  = step(h0_state, sum_h0);
      h1_next  = step(h1_state, sum_h1);
      out_next = step(out_state, sum_out);
   end

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         h0_state  <= RESET_STATE;
         h1_state  <= RESET_STATE;
         out_state <= RESET_STATE;
      end else begin
         h0_state  <= h0_next;
         h1_state  <= h1_next;
         out_state <= out_next;
      end
   end

endmodule

// File: tb/tb_bitstream_network.sv
// Directed bench for bitstream_network: saturated/zero weight corner cases,
// async reset behaviour, and a bit-exact reference model for default weights.
module tb_bitstream_network;

   logic       clk;
   logic       rst;
   logic [1:0] in_bits;
   logic       out_full, out_zero, out_def;

   int assertion_count = 0;
   int failure_count   = 0;

   logic [1:0] sng_stim [256];

   logic [7:0] m_lfsr [7];
   int         m_h0, m_h1, m_o;

   bitstream_network #(.W00(9'd256), .W01(9'd256), .W10(9'd256), .W11(9'd256),
                       .V0(9'd256), .V1(9'd256)) dut_full (
      .clk(clk), .n_rst(rst), .network_input(in_bits), .network_output(out_full));

   bitstream_network #(.W00(9'd0), .W01(9'd0), .W10(9'd0), .W11(9'd0),
                       .V0(9'd0), .V1(9'd0)) dut_zero (
      .clk(clk), .n_rst(rst), .network_input(in_bits), .network_output(out_zero));

   bitstream_network dut_def (
      .clk(clk), .n_rst(rst), .network_input(in_bits), .network_output(out_def));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset(input logic [1:0] pattern);
      @(negedge clk);
      rst     = 1'b1;
      in_bits = pattern;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Saturating counter reference: integer states, default weights of 128.
   task automatic model_reset();
      logic [7:0] v;
      for (int i = 0; i < 7; i++) begin
         v = 8'h5A ^ 8'(i);
         m_lfsr[i] = (v == 8'h00) ? 8'h01 : v;
      end
      m_h0 = 7;
      m_h1 = 7;
      m_o  = 7;
   endtask

   function automatic int sat(input int cur, input logic up);
      if (up) return (cur < 15) ? cur + 1 : 15;
      return (cur > 0) ? cur - 1 : 0;
   endfunction

   task automatic model_step(input logic [1:0] pattern, output logic expected);
      logic       wt [6];
      logic       s, s0, s1, so, h0o, h1o;
      logic [7:0] v;
      for (int i = 0; i < 6; i++) wt[i] = (int'(m_lfsr[i]) < 128);
      s   = m_lfsr[6][0];
      h0o = (m_h0 >= 8);
      h1o = (m_h1 >= 8);
      s0  = s ? (pattern[0] & wt[1]) : (pattern[1] & wt[0]);
      s1  = s ? (pattern[0] & wt[3]) : (pattern[1] & wt[2]);
      so  = s ? (h1o & wt[5]) : (h0o & wt[4]);
      m_h0 = sat(m_h0, s0);
      m_h1 = sat(m_h1, s1);
      m_o  = sat(m_o, so);
      for (int i = 0; i < 7; i++) begin
         v = m_lfsr[i];
         m_lfsr[i] = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
      end
      expected = (m_o >= 8);
   endtask

   // Output must stay low while reset is held, whatever the inputs do.
   task automatic test_reset();
      @(negedge clk);
      rst     = 1'b1;
      in_bits = 2'b11;
      for (int e = 0; e < 5; e++) begin
         @(posedge clk);
         #1;
         assertion_count++;
         if (out_full !== 1'b0) begin
            failure_count++;
            $display("[TB] FAIL reset_hold edge %0d: got %b expected 0", e, out_full);
         end
      end
   endtask

   // All-ones path: hidden rises at edge 1, output FSM dips to 6 then reaches 8 at edge 3.
   task automatic test_full_ones();
      logic exp_bit;
      apply_reset(2'b11);
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk);
         #1;
         exp_bit = (e >= 3);
         assertion_count++;
         if (out_full !== exp_bit) begin
            failure_count++;
            $display("[TB] FAIL full_ones edge %0d: got %b expected %b", e, out_full, exp_bit);
         end
         assertion_count++;
         if (out_zero !== 1'b0) begin
            failure_count++;
            $display("[TB] FAIL zero_weights edge %0d: got %b expected 0", e, out_zero);
         end
      end
   endtask

   task automatic test_all_zero();
      int ones = 0;
      apply_reset(2'b00);
      for (int e = 0; e < 256; e++) begin
         @(posedge clk);
         #1;
         if (out_full !== 1'b0) ones++;
      end
      assertion_count++;
      if (ones != 0) begin
         failure_count++;
         $display("[TB] FAIL all_zero: got %0d high cycles expected 0", ones);
      end
   endtask

   // From full saturation, hidden needs 8 edges to fall below half, output 7 more.
   task automatic test_saturation();
      int  high_edges = 0;
      bit  fell = 0;
      apply_reset(2'b11);
      repeat (100) @(negedge clk);
      assertion_count++;
      if (out_full !== 1'b1) begin
         failure_count++;
         $display("[TB] FAIL saturate_high: got %b expected 1", out_full);
      end
      in_bits = 2'b00;
      for (int e = 0; e < 40 && !fell; e++) begin
         @(posedge clk);
         #1;
         if (out_full === 1'b1) high_edges++;
         else fell = 1;
      end
      assertion_count++;
      if (!fell || high_edges != 15) begin
         failure_count++;
         $display("[TB] FAIL saturate_fall: got %0d high edges (fell=%0d) expected 15",
                  high_edges, fell);
      end
      repeat (20) @(posedge clk);
      #1;
      assertion_count++;
      if (out_full !== 1'b0) begin
         failure_count++;
         $display("[TB] FAIL saturate_floor: got %b expected 0", out_full);
      end
   endtask

   task automatic test_sng_default(input int pass);
      logic exp_bit;
      int   ones = 0, exp_ones = 0, bad = 0;
      apply_reset(2'b00);
      model_reset();
      for (int c = 0; c < 256; c++) begin
         in_bits = sng_stim[c];
         model_step(sng_stim[c], exp_bit);
         @(posedge clk);
         #1;
         if (exp_bit) exp_ones++;
         if (out_def === 1'b1) ones++;
         assertion_count++;
         if (out_def !== exp_bit) begin
            failure_count++;
            bad++;
            if (bad <= 5)
               $display("[TB] FAIL sng_bit pass %0d cycle %0d: got %b expected %b",
                        pass, c, out_def, exp_bit);
         end
         @(negedge clk);
      end
      assertion_count++;
      if (ones != exp_ones) begin
         failure_count++;
         $display("[TB] FAIL sng_count pass %0d: got %0d ones expected %0d", pass, ones, exp_ones);
      end
   endtask

   // Reset asserted between edges must clear the output without waiting for a clock.
   task automatic test_async_reset();
      logic exp_bit;
      apply_reset(2'b11);
      repeat (12) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      assertion_count++;
      if (out_full !== 1'b0) begin
         failure_count++;
         $display("[TB] FAIL async_drop: got %b expected 0", out_full);
      end
      repeat (2) @(posedge clk);
      #1;
      assertion_count++;
      if (out_full !== 1'b0) begin
         failure_count++;
         $display("[TB] FAIL async_hold: got %b expected 0", out_full);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk);
         #1;
         exp_bit = (e >= 3);
         assertion_count++;
         if (out_full !== exp_bit) begin
            failure_count++;
            $display("[TB] FAIL async_resume edge %0d: got %b expected %b", e, out_full, exp_bit);
         end
      end
   endtask

   initial begin
      rst     = 1'b1;
      in_bits = 2'b00;
      for (int c = 0; c < 256; c++) begin
         sng_stim[c][1] = ($urandom_range(0, 255) < 200);
         sng_stim[c][0] = ($urandom_range(0, 255) < 50);
      end
      test_reset();
      test_full_ones();
      test_all_zero();
      test_saturation();
      test_sng_default(1);
      test_sng_default(2);
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               assertion_count, failure_count);
      $finish;
   end

endmodule
